// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, one-cycle status pulses
// (write acknowledge, overflow, underflow) and count-decoded level flags.
// The depth does not have to be a power of two because the pointers wrap explicitly.
module sync_fifo #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntAFull = CntW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic wr_accept;
  logic rd_accept;

  // Level flags decoded from the count as it stood at the start of the cycle
  always_comb begin
    full        = (count_q == CntFull);
    empty       = (count_q == '0);
    almostfull  = (count_q == CntAFull);
    almostempty = (count_q == CntOne);
  end

  // Accept decisions and next-state for pointers and occupancy
  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;

    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end

    count_d = count_q;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; not cleared by reset, and a write issued during reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Pointers, occupancy, read data and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_ack    <= wr_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (rd_accept) begin
        data_out <= mem[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo. The driver updates a queue-based
// reference model and pushes the expected post-edge outputs; a monitor pops and compares.
module tb_sync_fifo;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         wr_ack, overflow, underflow, full, empty, almostfull, almostempty;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dout;
    logic         ack;
    logic         ovf;
    logic         unf;
    logic         fl;
    logic         em;
    logic         af;
    logic         ae;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] model_q [$];
  logic [W-1:0] model_dout = '0;
  int           n_cmp = 0;
  int           n_err = 0;
  bit           done = 0;

  // Apply one cycle of stimulus and record what the outputs must be after the edge
  task automatic cyc(input bit rst, input bit we, input bit re, input logic [W-1:0] din);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    @(negedge clk);
    rst_n   = !rst;
    wr_en   = we;
    rd_en   = re;
    data_in = din;
    e.ack = 0;
    e.ovf = 0;
    e.unf = 0;
    if (rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      was_full  = (model_q.size() == D);
      was_empty = (model_q.size() == 0);
      if (re) begin
        if (was_empty) e.unf = 1;
        else model_dout = model_q.pop_front();
      end
      if (we) begin
        if (was_full) e.ovf = 1;
        else begin
          model_q.push_back(din);
          e.ack = 1;
        end
      end
    end
    e.dout = model_dout;
    e.fl   = (model_q.size() == D);
    e.em   = (model_q.size() == 0);
    e.af   = (model_q.size() == D - 1);
    e.ae   = (model_q.size() == 1);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every recorded expectation just after the edge it belongs to
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.dout));
        check("wr_ack", 32'(wr_ack), 32'(e.ack));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("underflow", 32'(underflow), 32'(e.unf));
        check("full", 32'(full), 32'(e.fl));
        check("empty", 32'(empty), 32'(e.em));
        check("almostfull", 32'(almostfull), 32'(e.af));
        check("almostempty", 32'(almostempty), 32'(e.ae));
      end
    end
  end

  // Driver
  initial begin
    int mode;
    // 1: single write then single read
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, 16'hA5A5);
    cyc(0, 0, 1, '0);
    // 2: fill, overflow, drain
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, W'(i));
    cyc(0, 1, 0, 16'd9);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, '0);
    // 3: underflow from empty, then idle
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    // 4: simultaneous access when full, then when empty
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, W'(i));
    cyc(0, 1, 1, 16'd99);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, '0);
    cyc(0, 1, 1, 16'd7);
    cyc(0, 0, 1, '0);
    // 5: bursts across pointer wrap
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, W'(16'h100 + r * 5 + i));
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, '0);
    end
    // 6: reset with a concurrent write while partly full
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, W'(16'h200 + i));
    cyc(1, 1, 0, 16'hBEEF);
    cyc(0, 0, 1, '0);
    // Random phase, alternating write-heavy and read-heavy windows
    for (int n = 0; n < 800; n++) begin
      mode = (n / 40) % 2;
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 99) < (mode ? 75 : 30)),
          ($urandom_range(0, 99) < (mode ? 30 : 75)),
          W'($urandom));
    end
    cyc(0, 0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
